// File: rtl/fir_fold_pkg.sv
// Shared definitions for the folded FIR MAC scheduler.
// Holds the default datapath widths, the tap count, the FSM state
// encoding and a constant clog2 helper used to size tap indices.
package fir_fold_pkg;

  localparam int DEFAULT_NUM_TAPS = 16;
  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_COEF_W   = 11;
  localparam int DEFAULT_PROD_W   = DEFAULT_DATA_W + DEFAULT_COEF_W;
  localparam int DEFAULT_ACC_W    = 32;

  // Scheduler states: accept, multiply-accumulate, drain pipeline, present result
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Smallest n such that 2**n >= value
  function automatic int fir_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_fold_mul.sv
// Purely combinational signed multiplier shared by every tap of the
// folded FIR. Both operands are sign-extended to the product width so
// the full-precision result needs no further correction.
// Ports:
//   a_i    signed sample operand   (DATA_W)
//   b_i    signed coefficient      (COEF_W)
//   prod_o signed product          (PROD_W)
module fir_fold_mul
  import fir_fold_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int COEF_W = DEFAULT_COEF_W,
  parameter int PROD_W = DEFAULT_PROD_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [PROD_W-1:0] prod_o
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  assign a_ext  = {{(PROD_W-DATA_W){a_i[DATA_W-1]}}, a_i};
  assign b_ext  = {{(PROD_W-COEF_W){b_i[COEF_W-1]}}, b_i};
  assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/fir_fold_mac_scheduler.sv
// Sequencer for a folded direct-form FIR. One sample is accepted per
// handshake into a circular delay line, then NUM_TAPS MACs run one per
// cycle through a single shared multiplier, and the full-precision sum
// is held on a valid/ready output until taken.
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   in_data/in_valid/in_ready       sample input handshake
//   coef_we/coef_addr/coef_data     coefficient bank write (IDLE only)
//   coef_err                        pulse: a write was dropped while busy
//   out_data/out_valid/out_ready    filter result handshake
//   busy                            high outside IDLE
module fir_fold_mac_scheduler
  import fir_fold_pkg::*;
#(
  parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int COEF_W   = DEFAULT_COEF_W,
  parameter int PROD_W   = DEFAULT_PROD_W,
  parameter int ACC_W    = DEFAULT_ACC_W,
  localparam int AW      = fir_clog2(NUM_TAPS)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] dline_q [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q  [NUM_TAPS];
  logic [AW-1:0]            wptr_q;
  logic [AW-1:0]            k_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     coef_err_q;

  logic [AW-1:0]            rd_idx;
  logic signed [PROD_W-1:0] prod_w;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     is_idle;

  assign is_idle = (state_q == ST_IDLE);

  // Tap k pairs h[k] with x[n-k]; the power-of-two depth makes the
  // pointer subtraction wrap naturally.
  assign rd_idx   = wptr_q - k_q;
  assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  fir_fold_mul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .PROD_W (PROD_W)
  ) u_mul (
    .a_i    (dline_q[rd_idx]),
    .b_i    (coef_q[k_q]),
    .prod_o (prod_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)          state_d = ST_MAC;
      ST_MAC:   if (k_q == LAST_TAP)   state_d = ST_DRAIN;
      ST_DRAIN:                        state_d = ST_OUT;
      ST_OUT:   if (out_ready)         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // The product register is cleared on accept so the first MAC cycle,
  // which has no product yet, accumulates zero. DRAIN folds in the
  // product of the last tap.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      k_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      coef_err_q <= coef_we && !is_idle;
      if (coef_we && is_idle) begin
        coef_q[coef_addr] <= coef_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            dline_q[wptr_q] <= in_data;
            acc_q           <= '0;
            prod_q          <= '0;
            k_q             <= '0;
          end
        end
        ST_MAC: begin
          prod_q <= prod_w;
          acc_q  <= acc_q + prod_ext;
          k_q    <= k_q + AW'(1);
        end
        ST_DRAIN: begin
          acc_q  <= acc_q + prod_ext;
          wptr_q <= wptr_q + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = is_idle;
  assign busy      = !is_idle;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = acc_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_fold_mac_scheduler.sv
// Self-checking bench for fir_fold_mac_scheduler. A reference model of
// the coefficient bank and sample history computes each expected sum
// when a sample is accepted and pushes it onto a scoreboard queue; the
// entry is popped and compared when the DUT presents its result.
module tb_fir_fold_mac_scheduler;

  localparam int NT = 16;

  logic               clock;
  logic               reset;
  logic signed [15:0] inData;
  logic               inValid;
  logic               inReady;
  logic               coefWe;
  logic [3:0]         coefAddr;
  logic signed [10:0] coefData;
  logic               coefErr;
  logic signed [31:0] outData;
  logic               outValid;
  logic               outReady;
  logic               busy;

  int testsRun  = 0;
  int failCount = 0;

  int tbCoef [NT];
  int tbHist [NT];
  logic signed [31:0] sbQueue [$];

  fir_fold_mac_scheduler dut (
    .ap_clk    (clock),
    .ap_rst    (reset),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .coef_we   (coefWe),
    .coef_addr (coefAddr),
    .coef_data (coefData),
    .coef_err  (coefErr),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; everything is driven and sampled 1 ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < NT; i++) begin
      tbCoef[i] = 0;
      tbHist[i] = 0;
    end
    sbQueue.delete();
  endtask

  task automatic writeCoef(input logic [3:0] addr, input logic signed [10:0] data);
    coefWe   = 1'b1;
    coefAddr = addr;
    coefData = data;
    tick();
    coefWe   = 1'b0;
    tbCoef[addr] = data;
  endtask

  // Drive one accepted sample and push the model's expected sum
  task automatic acceptSample(input logic signed [15:0] x);
    longint sum;
    inData  = x;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int i = NT - 1; i > 0; i--) tbHist[i] = tbHist[i-1];
    tbHist[0] = x;
    sum = 0;
    for (int k = 0; k < NT; k++) sum += longint'(tbCoef[k]) * longint'(tbHist[k]);
    sbQueue.push_back(32'(sum));
  endtask

  // Pop the scoreboard and compare against the result currently on the output
  task automatic waitAndScore(output int lat);
    logic signed [31:0] exp;
    lat = 1;
    while (!outValid && lat < 100) begin
      tick();
      lat++;
    end
    testsRun++;
    exp = (sbQueue.size() > 0) ? sbQueue.pop_front() : 32'sd0;
    if (!outValid) begin
      failCount++;
      $display("[TB] FAIL scoreboard_timeout: out_valid=%0b after %0d cycles, required 1", outValid, lat);
    end else if (outData !== exp) begin
      failCount++;
      $display("[TB] FAIL scoreboard_out_data: got %0d, expected %0d", outData, exp);
    end
  endtask

  task automatic feedSample(input logic signed [15:0] x, input bit doWrite,
                            input logic [3:0] wAddr, input logic signed [10:0] wData,
                            output logic signed [31:0] got, output int lat,
                            output int waited);
    waited = 0;
    while (!inReady && waited < 100) begin
      tick();
      waited++;
    end
    if (doWrite) begin
      coefWe   = 1'b1;
      coefAddr = wAddr;
      coefData = wData;
      tbCoef[wAddr] = wData;
    end
    acceptSample(x);
    coefWe = 1'b0;
    waitAndScore(lat);
    got = outData;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    testsRun++;
    if (inReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", inReady); end
    testsRun++;
    if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", outValid); end
    testsRun++;
    if (outData !== 32'sd0) begin failCount++; $display("[TB] FAIL reset_out_data: got %0d, expected 0", outData); end
    testsRun++;
    if (coefErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_coef_err: got %b, expected 0", coefErr); end
    testsRun++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    clearModel();
  endtask

  task automatic runImpulse(input string tag, input bit zeroCoefs);
    logic signed [31:0] got;
    logic signed [31:0] want;
    int lat, waited;
    for (int i = 0; i <= NT; i++) begin
      feedSample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, 4'd0, 11'sd0, got, lat, waited);
      want = (zeroCoefs || i >= NT) ? 32'sd0 : 32'(i + 1);
      testsRun++;
      if (got !== want) begin
        failCount++;
        $display("[TB] FAIL %s_out%0d: got %0d, expected %0d", tag, i, got, want);
      end
    end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < NT; k++) writeCoef(4'(k), 11'(k + 1));
    runImpulse("impulse", 1'b0);
  endtask

  task automatic test_extreme();
    logic signed [31:0] got;
    int lat, waited;
    for (int k = 0; k < NT; k++) writeCoef(4'(k), 11'h400);
    for (int i = 0; i < NT; i++) begin
      feedSample(16'h8000, 1'b0, 4'd0, 11'sd0, got, lat, waited);
      if (i == 0) begin
        testsRun++;
        if (got !== 32'sd33554432) begin failCount++; $display("[TB] FAIL extreme_first: got %0d, expected 33554432", got); end
      end
      if (i == NT - 1) begin
        testsRun++;
        if (got !== 32'sd536870912) begin failCount++; $display("[TB] FAIL extreme_last: got %0d, expected 536870912", got); end
      end
    end
  endtask

  task automatic test_latency();
    logic signed [31:0] got;
    int lat, waited;
    outReady = 1'b1;
    feedSample(16'sd100, 1'b0, 4'd0, 11'sd0, got, lat, waited);
    testsRun++;
    if (lat !== 18) begin failCount++; $display("[TB] FAIL latency_first: got %0d, expected 18", lat); end
    testsRun++;
    if (inReady !== 1'b1) begin failCount++; $display("[TB] FAIL latency_in_ready_back: got %b, expected 1", inReady); end
    feedSample(-16'sd50, 1'b0, 4'd0, 11'sd0, got, lat, waited);
    testsRun++;
    if (waited !== 0) begin failCount++; $display("[TB] FAIL back_to_back_wait: got %0d, expected 0", waited); end
    testsRun++;
    if (lat !== 18) begin failCount++; $display("[TB] FAIL latency_second: got %0d, expected 18", lat); end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] held;
    int lat;
    outReady = 1'b0;
    acceptSample(16'sd1234);
    waitAndScore(lat);
    held = outData;
    for (int c = 0; c < 5; c++) begin
      testsRun++;
      if (outValid !== 1'b1 || outData !== held || inReady !== 1'b0 || busy !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL backpressure_hold%0d: valid=%b data=%0d in_ready=%b busy=%b, expected 1/%0d/0/1",
                 c, outValid, outData, inReady, busy, held);
      end
      tick();
    end
    outReady = 1'b1;
    tick();
    testsRun++;
    if (busy !== 1'b0 || inReady !== 1'b1 || outValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL backpressure_release: busy=%b in_ready=%b valid=%b, expected 0/1/0", busy, inReady, outValid);
    end
  endtask

  task automatic test_busy_coef_write();
    logic signed [31:0] got;
    int lat, waited;
    acceptSample(16'sd1000);
    tick();
    tick();
    coefWe   = 1'b1;
    coefAddr = 4'd0;
    coefData = 11'sd7;
    tick();
    coefWe = 1'b0;
    testsRun++;
    if (coefErr !== 1'b1) begin failCount++; $display("[TB] FAIL busy_write_err_pulse: got %b, expected 1", coefErr); end
    tick();
    testsRun++;
    if (coefErr !== 1'b0) begin failCount++; $display("[TB] FAIL busy_write_err_clear: got %b, expected 0", coefErr); end
    waitAndScore(lat);
    tick();
    writeCoef(4'd0, 11'sd7);
    testsRun++;
    if (coefErr !== 1'b0) begin failCount++; $display("[TB] FAIL idle_write_err: got %b, expected 0", coefErr); end
    feedSample(16'sd900, 1'b0, 4'd0, 11'sd0, got, lat, waited);
    feedSample(16'sd300, 1'b1, 4'd1, 11'sd5, got, lat, waited);
    writeCoef(4'd2, 11'sd100);
    writeCoef(4'd2, -11'sd3);
    feedSample(-16'sd700, 1'b0, 4'd0, 11'sd0, got, lat, waited);
  endtask

  task automatic test_reset_mid_mac();
    acceptSample(16'sd500);
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    testsRun++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || outData !== 32'sd0) begin
      failCount++;
      $display("[TB] FAIL mid_mac_reset: in_ready=%b valid=%b busy=%b data=%0d, expected 1/0/0/0",
               inReady, outValid, busy, outData);
    end
    clearModel();
    runImpulse("zero_coef_impulse", 1'b1);
    for (int k = 0; k < NT; k++) writeCoef(4'(k), 11'(k + 1));
    runImpulse("reimpulse", 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    inData   = '0;
    inValid  = 1'b0;
    coefWe   = 1'b0;
    coefAddr = '0;
    coefData = '0;
    outReady = 1'b1;
    test_reset();
    test_impulse();
    test_extreme();
    test_latency();
    test_backpressure();
    test_busy_coef_write();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/fir_fold_mac_scheduler.md
Name: fir_fold_mac_scheduler

Overview:
Sequencer for a folded (time-multiplexed) direct-form FIR that shares one signed 16s x 11s multiplier across all taps.
- Accepts one input sample per valid/ready handshake and stores it in a circular delay line.
- Issues NUM_TAPS multiply-accumulate operations, one per cycle, through the single shared multiplier.
- Returns the full-precision filter sum on a valid/ready output.
- Owns the runtime-writable coefficient bank and sits between the sample source and the decimation/filterbank stage.

Parameters:
- NUM_TAPS, 16, number of taps; must be a power of two, ≥2.
- DATA_W, 16, signed sample width.
- COEF_W, 11, signed coefficient width.
- PROD_W, 27, signed product width; equals DATA_W+COEF_W.
- ACC_W, 32, signed accumulator/output width; must be ≥ PROD_W+clog2(NUM_TAPS).

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst  in  1  synchronous active-high reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  sample present.
- in_ready  out  1  scheduler can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NUM_TAPS)  tap index k.
- coef_data  in  COEF_W  signed coefficient h[k].
- coef_err  out  1  one-cycle pulse: write dropped because block was busy.
- out_data  out  ACC_W  signed y[n] = sum over k of h[k]*x[n-k].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (ap_rst=1 at an edge, any state, including mid-operation):
- Next cycle: state=IDLE, in_ready=1, out_valid=0, out_data=0, coef_err=0, busy=0.
- Delay line, write pointer, tap counter, product register and accumulator are cleared to 0.
- Coefficient bank is cleared to 0.

State machine: IDLE -> MAC -> DRAIN -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready at cycle T: buf[wptr]<=in_data, acc<=0, k<=0, go to MAC.
- MAC (cycles T+1..T+NUM_TAPS):
  - Multiplier operands are buf[(wptr-k) mod NUM_TAPS] and h[k].
  - prod_reg <= signed product, registered.
  - acc += sign-extended prod_reg from the previous MAC cycle.
  - k increments each cycle. Leave MAC when k=NUM_TAPS-1.
- DRAIN (T+NUM_TAPS+1): the last product is accumulated. wptr<=wptr+1, wrapping modulo NUM_TAPS.
- OUT (from T+NUM_TAPS+2): out_valid=1 and out_data=acc, both held stable until out_ready=1. Return to IDLE on the next cycle after out_ready=1.

Timing:
- Latency from accept to out_valid is NUM_TAPS+2 cycles; 18 at the defaults.
- Minimum sample period is NUM_TAPS+3 cycles.
- in_ready=0 outside IDLE; in_valid is ignored there.

Arithmetic:
- Full-precision signed arithmetic throughout; product sign-extended to ACC_W.
- No rounding and no saturation. ACC_W sizing guarantees no overflow.

Coefficient writes:
- Take effect only in IDLE, visible from the next cycle.
- A write in the same cycle as a sample accept applies to that sample's MAC.
- A write with busy=1 is dropped; coef_err pulses on the following cycle.
- Repeated writes to the same address: the last one wins.

Delay line:
- Initial contents are 0, so the first NUM_TAPS-1 outputs use zero history.
- The pointer wraps without a gap.

Decomposition:
- Package fir_fold_pkg:
  - state encoding (IDLE, MAC, DRAIN, OUT);
  - default widths DATA_W, COEF_W, PROD_W, ACC_W;
  - NUM_TAPS and a clog2 constant function.
- Sub-module fir_fold_mul: a purely combinational signed DATA_W x COEF_W -> PROD_W multiplier, instanced once. The product register stays in the scheduler.

Test Plan:
- Impulse response: after reset, write h[k]=k+1 for k=0..15; feed x=1 then 16 zeros with out_ready=1 -> outputs 1,2,...,16, then 0.
- Extreme values: all h=-1024; feed x=-32768 sixteen times -> 16th output = 536870912 (0x20000000), no wrap. First output = 33554432.
- Latency and throughput: accept at cycle T with out_ready=1 -> out_valid only at T+18; in_ready back to 1 at T+19; next accept possible at T+19.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_data unchanged; in_ready=0; busy=1. Release -> IDLE next cycle.
- Busy coefficient write: write h[0]=7 during MAC -> coef_err pulses once, write ignored, output uses the old h[0]. Same write in IDLE -> applied.
- Reset mid-MAC at k=5 -> next cycle in_ready=1, out_valid=0, busy=0. The impulse test afterwards gives all zeros because coefficients were cleared; after rewriting coefficients it matches the first scenario.
